// File: rtl/and_nb_persist.sv
// Registered WIDTH-input AND with per-input inversion mask and a consecutive-edge persistence filter.
// Optional sticky output is enabled by defining AND_NB_PERSIST_STICKY_EN.
module and_nb_persist #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}},
    parameter int               PERSIST  = 1
) (
    input  logic             C,
    input  logic             CLRN,
    input  logic             CE,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] I,
    output logic             O,
    output logic             RISE
);

    localparam int            CW        = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);

    logic          term;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          hit;
    logic          o_n;

    assign term = &(I ^ INV_MASK);

    // Saturating run counter: any false sample restarts the run from zero.
    always_comb begin
        cnt_n = '0;
        if (term) begin
            cnt_n = (cnt == PERSIST_C) ? cnt : cnt + CW'(1);
        end
        hit = (cnt_n == PERSIST_C);
`ifdef AND_NB_PERSIST_STICKY_EN
        o_n = O | hit;
`else
        o_n = hit;
`endif
    end

    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            cnt  <= '0;
            O    <= 1'b0;
            RISE <= 1'b0;
        end else if (SCLR) begin
            cnt  <= '0;
            O    <= 1'b0;
            RISE <= 1'b0;
        end else if (CE) begin
            cnt  <= cnt_n;
            O    <= o_n;
            RISE <= hit & ~O;
        end else begin
            RISE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_and_nb_persist.sv
// Directed testbench for and_nb_persist using four differently parameterised instances.
module tb_and_nb_persist;

    logic C = 1'b0;
    logic CLRN;
    int   checks   = 0;
    int   failures = 0;

    logic       ce_d, sclr_d, o_d, rise_d;
    logic [3:0] i_d;
    logic       ce_3, sclr_3, o_3, rise_3;
    logic [3:0] i_3;
    logic       ce_2, sclr_2, o_2, rise_2;
    logic [3:0] i_2;
    logic       ce_8, sclr_8, o_8, rise_8;
    logic [7:0] i_8;

    always #5 C = ~C;

    and_nb_persist dut_def (
        .C(C), .CLRN(CLRN), .CE(ce_d), .SCLR(sclr_d), .I(i_d), .O(o_d), .RISE(rise_d)
    );

    and_nb_persist #(.WIDTH(4), .INV_MASK(4'h0), .PERSIST(3)) dut_p3 (
        .C(C), .CLRN(CLRN), .CE(ce_3), .SCLR(sclr_3), .I(i_3), .O(o_3), .RISE(rise_3)
    );

    and_nb_persist #(.WIDTH(4), .INV_MASK(4'h0), .PERSIST(2)) dut_p2 (
        .C(C), .CLRN(CLRN), .CE(ce_2), .SCLR(sclr_2), .I(i_2), .O(o_2), .RISE(rise_2)
    );

    and_nb_persist #(.WIDTH(8), .INV_MASK(8'hA5), .PERSIST(1)) dut_w8 (
        .C(C), .CLRN(CLRN), .CE(ce_8), .SCLR(sclr_8), .I(i_8), .O(o_8), .RISE(rise_8)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        CLRN = 1'b0;
        ce_d = 1'b1; sclr_d = 1'b0; i_d = 4'h0;
        ce_3 = 1'b0; sclr_3 = 1'b0; i_3 = 4'h0;
        ce_2 = 1'b0; sclr_2 = 1'b0; i_2 = 4'h0;
        ce_8 = 1'b0; sclr_8 = 1'b0; i_8 = 8'h00;
        tick();
        tick();
        checks++;
        if ({o_d, rise_d} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_hold: O,RISE=%b expected 00", {o_d, rise_d});
        end
        @(negedge C);
        CLRN = 1'b1;
        tick();
        checks++;
        if ({o_d, rise_d} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL reset_first_edge: O,RISE=%b expected 11", {o_d, rise_d});
        end
        tick();
        checks++;
        if ({o_d, rise_d} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_second_edge: O,RISE=%b expected 10", {o_d, rise_d});
        end
        i_d = 4'h1;
        tick();
        checks++;
        if ({o_d, rise_d} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_term_false: O,RISE=%b expected 00", {o_d, rise_d});
        end
    endtask

    task automatic test_persistence();
        logic [3:0] pat   [8] = '{4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic       exp_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_r [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ce_3 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_3 = pat[k];
            tick();
            checks++;
            if ({o_3, rise_3} !== {exp_o[k], exp_r[k]}) begin
                failures++;
                $display("[TB] FAIL persist_edge%0d: O,RISE=%b expected %b", k, {o_3, rise_3}, {exp_o[k], exp_r[k]});
            end
        end
    endtask

    task automatic test_ce_hold();
        logic ce_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic exp_o  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        i_2 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            ce_2 = ce_pat[k];
            tick();
            checks++;
            if ({o_2, rise_2} !== {exp_o[k], exp_o[k]}) begin
                failures++;
                $display("[TB] FAIL ce_hold_edge%0d: O,RISE=%b expected %b", k, {o_2, rise_2}, {exp_o[k], exp_o[k]});
            end
        end
        ce_2 = 1'b0;
        tick();
        checks++;
        if ({o_2, rise_2} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ce_low_rise_clear: O,RISE=%b expected 10", {o_2, rise_2});
        end
    endtask

    task automatic test_priority_clear();
        ce_2 = 1'b1; sclr_2 = 1'b1; i_2 = 4'hF;
        tick();
        checks++;
        if ({o_2, rise_2} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL sclr_priority: O,RISE=%b expected 00", {o_2, rise_2});
        end
        sclr_2 = 1'b0;
        tick();
        checks++;
        if (o_2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sclr_restart_first: O=%b expected 0", o_2);
        end
        tick();
        checks++;
        if ({o_2, rise_2} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL sclr_restart_second: O,RISE=%b expected 11", {o_2, rise_2});
        end
        tick();
        CLRN = 1'b0;
        #1;
        checks++;
        if ({o_2, rise_2} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL async_clear: O,RISE=%b expected 00", {o_2, rise_2});
        end
        #2;
        CLRN = 1'b1;
        tick();
        checks++;
        if (o_2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clrn_restart_first: O=%b expected 0", o_2);
        end
        tick();
        checks++;
        if ({o_2, rise_2} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL clrn_restart_second: O,RISE=%b expected 11", {o_2, rise_2});
        end
    endtask

    task automatic test_mixed_mask();
        ce_8 = 1'b1;
        i_8  = 8'h5A;
        tick();
        checks++;
        if (o_8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mask_5a: O=%b expected 1", o_8);
        end
        i_8 = 8'h5B;
        tick();
        checks++;
        if (o_8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mask_5b: O=%b expected 0", o_8);
        end
    endtask

    task automatic test_hold_off();
        logic exp_o;
`ifdef AND_NB_PERSIST_STICKY_EN
        exp_o = 1'b1;
`else
        exp_o = 1'b0;
`endif
        ce_d = 1'b1; sclr_d = 1'b0; i_d = 4'h0;
        tick();
        tick();
        checks++;
        if (o_d !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_set: O=%b expected 1", o_d);
        end
        i_d = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({o_d, rise_d} !== {exp_o, 1'b0}) begin
                failures++;
                $display("[TB] FAIL hold_term_false%0d: O,RISE=%b expected %b", k, {o_d, rise_d}, {exp_o, 1'b0});
            end
        end
        sclr_d = 1'b1;
        tick();
        checks++;
        if ({o_d, rise_d} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL hold_sclr: O,RISE=%b expected 00", {o_d, rise_d});
        end
        sclr_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_persistence();
        test_ce_hold();
        test_priority_clear();
        test_mixed_mask();
        test_hold_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
